// File: rtl/hsid_x_reg_initiator.sv
// hsid_x_reg_initiator: single-outstanding valid/ready command to register-bus initiator
// with a per-transaction ready timeout; the request/response buses are flattened to ports.
module hsid_x_reg_initiator #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        reg_req_valid_o,
  output logic        reg_req_write_o,
  output logic [3:0]  reg_req_wstrb_o,
  output logic [31:0] reg_req_addr_o,
  output logic [31:0] reg_req_wdata_o,
  input  logic        reg_rsp_error_i,
  input  logic        reg_rsp_ready_i,
  input  logic [31:0] reg_rsp_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output logic        busy_o
);
  localparam int unsigned CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic [3:0]       req_wstrb_q, req_wstrb_d;
  logic [31:0]      req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             done, expire;
  // ready wins over a simultaneous timeout expiry
  assign done   = state_q == REQ && req_valid_q && reg_rsp_ready_i;
  assign expire = TIMEOUT != 0 && state_q == REQ && !done && cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_valid_d   = req_valid_q;
    req_write_d   = req_write_q;
    req_wstrb_d   = req_wstrb_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    if (state_q == IDLE && cmd_valid_i) begin
      state_d     = REQ;
      cnt_d       = '0;
      req_valid_d = 1'b1;
      req_write_d = cmd_write_i;
      req_addr_d  = cmd_addr_i;
      req_wstrb_d = cmd_write_i ? cmd_wstrb_i : 4'h0;
      req_wdata_d = cmd_write_i ? cmd_wdata_i : 32'h0;
    end else if (state_q == REQ) begin
      cnt_d = cnt_q + 1'b1;
      if (done || expire) begin
        state_d       = RESP;
        req_valid_d   = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = !done;
        rsp_error_d   = done ? reg_rsp_error_i : 1'b1;
        rsp_rdata_d   = done && !req_write_q ? reg_rsp_rdata_i : 32'h0;
      end
    end else if (state_q == RESP && rsp_ready_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_valid_q   <= 1'b0;
      req_write_q   <= 1'b0;
      req_wstrb_q   <= 4'h0;
      req_addr_q    <= 32'h0;
      req_wdata_q   <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_valid_q   <= req_valid_d;
      req_write_q   <= req_write_d;
      req_wstrb_q   <= req_wstrb_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end
  assign cmd_ready_o     = state_q == IDLE;
  assign busy_o          = state_q != IDLE;
  assign reg_req_valid_o = req_valid_q;
  assign reg_req_write_o = req_write_q;
  assign reg_req_wstrb_o = req_wstrb_q;
  assign reg_req_addr_o  = req_addr_q;
  assign reg_req_wdata_o = req_wdata_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_error_o     = rsp_error_q;
  assign rsp_timeout_o   = rsp_timeout_q;
endmodule

// File: tb/tb_hsid_x_reg_initiator.sv
// tb_hsid_x_reg_initiator: directed plus random transactions against a per-transaction
// outcome model (valid-cycle count, rdata/error/timeout) derived from wait length.
module tb_hsid_x_reg_initiator;
  localparam int T = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        req_valid, req_write;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready_bus, rsp_error_bus;
  logic [31:0] rsp_rdata_bus;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  int          total = 0, bad = 0, vcnt = 0, wait_n = 0;
  logic [31:0] rd_v = '0;
  logic        er_v = 1'b0;
  always #5 clk = ~clk;
  // responder: ready after wait_n stalled cycles; data lines carry junk when not ready
  always @(posedge clk) vcnt <= req_valid ? vcnt + 1 : 0;
  assign rsp_ready_bus = req_valid && vcnt == wait_n;
  assign rsp_rdata_bus = rsp_ready_bus ? rd_v : ~rd_v;
  assign rsp_error_bus = rsp_ready_bus ? er_v : ~er_v;
  hsid_x_reg_initiator #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .reg_req_valid_o(req_valid), .reg_req_write_o(req_write), .reg_req_wstrb_o(req_wstrb),
    .reg_req_addr_o(req_addr), .reg_req_wdata_o(req_wdata),
    .reg_rsp_error_i(rsp_error_bus), .reg_rsp_ready_i(rsp_ready_bus), .reg_rsp_rdata_i(rsp_rdata_bus),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int w, input logic [31:0] rd,
                     input logic er, input int hold);
    bit          to;
    int          exp_n, n, g;
    logic [31:0] exp_rd;
    to     = w >= T;
    exp_n  = to ? T : w + 1;
    exp_rd = (to || wr) ? 32'h0 : rd;
    wait_n = w;
    rd_v   = rd;
    er_v   = er;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = hold > 0;
    n = 0;
    g = 0;
    while (!rsp_valid && g < 40) begin
      if (req_valid) begin
        n++;
        chk("req_write", {31'b0, req_write}, {31'b0, wr});
        chk("req_addr", req_addr, a);
        chk("req_wstrb", {28'b0, req_wstrb}, wr ? {28'b0, ws} : 32'h0);
        chk("req_wdata", req_wdata, wr ? wd : 32'h0);
      end
      chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      step();
      g++;
    end
    chk("rsp_valid_rise", {31'b0, rsp_valid}, 32'd1);
    chk("valid_cycles", n, exp_n);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_error", {31'b0, rsp_error}, {31'b0, to ? 1'b1 : er});
      chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, to});
      chk("resp_no_req", {31'b0, req_valid}, 32'd0);
      chk("resp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("resp_busy", {31'b0, busy}, 32'd1);
      if (i < hold) begin
        step();
        chk("rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    chk("busy_clear", {31'b0, busy}, 32'd0);
  endtask
  initial begin
    repeat (2) step();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_fields", {req_write, req_wstrb, 27'b0} | req_addr | req_wdata, 32'h0);
    chk("rst_rsp", {29'b0, rsp_valid, rsp_error, rsp_timeout} | rsp_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    txn(1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0, 0);
    txn(1'b1, 32'h04, 32'h12345678, 4'b0011, 0, 32'hA5A5A5A5, 1'b0, 0);
    txn(1'b0, 32'hFC, 32'hFFFFFFFF, 4'hF, 1, 32'h01234567, 1'b1, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 50, 32'h55555555, 1'b0, 0);
    txn(1'b0, 32'h24, 32'h0, 4'h0, T - 1, 32'hCAFEF00D, 1'b0, 0);
    txn(1'b1, 32'h33, 32'hFFFF0000, 4'h0, 3, 32'h0, 1'b0, 5);
    for (int k = 0; k < 25; k++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 10),
          $urandom, 1'($urandom), $urandom_range(0, 2));
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    cmd_valid = 1'b1;
    wait_n    = 100;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", {31'b0, req_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_async_busy", {31'b0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    txn(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h89ABCDEF, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
